// File: rtl/display_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_pkg : shared state encoding and pin constants for the scan controller
// Revision    : 1.0
// ---------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Segment bit positions on the segment bus (a is the MSB, the point the LSB)
  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_P = 0;

  localparam logic [7:0] DIGIT_OFF    = 8'hFF;
  localparam logic [7:0] SEG_OFF      = 8'hFF;
  localparam logic [7:0] SEG_DOT_ONLY = ~(8'd1 << SEG_P);

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_to_seg7 : nibble to active-low a..g glyph (bit 6 = a, bit 0 = g)
// Revision    : 1.0
// ---------------------------------------------------------------------------
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = 7'b1111111;
    case (nibble)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      4'hF: glyph = 7'b0111000;
      default: glyph = 7'b1111111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_scan_controller : frame-coherent PWM scan of four seven-segment digits
// Revision                : 1.0
// ---------------------------------------------------------------------------
module display_scan_controller
  import display_pkg::*;
#(
  parameter int TICK_DIV = 625
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dots,
  input  logic [2:0]  bright,
  input  logic        lz_blank,
  output logic [7:0]  digit,
  output logic [7:0]  segment,
  output logic        frame_start
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_sub;
  logic [1:0]    r_idx;

  logic [15:0]   r_value_s;
  logic [3:0]    r_dots_s;
  logic [2:0]    r_bright_s;
  logic          r_lz_blank_s;

  logic          w_tick;
  logic [3:0]    w_nibble;
  logic [6:0]    w_glyph;
  logic [3:0]    w_blank;
  logic          w_dot;
  logic          w_lit;
  logic [7:0]    w_digit;
  logic [7:0]    w_seg;

  assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
  assign w_nibble = r_value_s[{r_idx, 2'b00} +: 4];
  assign w_dot    = r_dots_s[r_idx];

  // A digit is a leading zero only if it and every digit to its left are zero
  assign w_blank[0] = 1'b0;
  assign w_blank[1] = r_lz_blank_s && (r_value_s[15:4]  == 12'h000);
  assign w_blank[2] = r_lz_blank_s && (r_value_s[15:8]  == 8'h00);
  assign w_blank[3] = r_lz_blank_s && (r_value_s[15:12] == 4'h0);

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (w_nibble),
    .glyph  (w_glyph)
  );

  assign w_lit   = (r_state == SCAN) && (r_sub < r_bright_s) &&
                   !(w_blank[r_idx] && !w_dot);
  assign w_digit = ~(8'd1 << r_idx);
  assign w_seg   = w_blank[r_idx] ? SEG_DOT_ONLY : {w_glyph, ~w_dot};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= LOAD;
      r_presc      <= '0;
      r_sub        <= '0;
      r_idx        <= '0;
      r_value_s    <= '0;
      r_dots_s     <= '0;
      r_bright_s   <= '0;
      r_lz_blank_s <= 1'b0;
      digit        <= DIGIT_OFF;
      segment      <= SEG_OFF;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      digit       <= w_lit ? w_digit : DIGIT_OFF;
      segment     <= w_lit ? w_seg   : SEG_OFF;
      case (r_state)
        LOAD: begin
          r_value_s    <= value;
          r_dots_s     <= dots;
          r_bright_s   <= bright;
          r_lz_blank_s <= lz_blank;
          frame_start  <= 1'b1;
          r_presc      <= '0;
          r_sub        <= '0;
          r_idx        <= '0;
          r_state      <= SCAN;
        end
        SCAN: begin
          if (w_tick) begin
            r_presc <= '0;
            r_sub   <= r_sub + 3'd1;
            if (r_sub == 3'd7) begin
              r_idx <= r_idx + 2'd1;
              if (r_idx == 2'd3) begin
                r_state <= LOAD;
              end
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire
